// File: rtl/vfifo_pkg.sv
// Shared defaults, pointer type and pointer comparison helpers for the vfifo read/write sides.
package vfifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // Binary pointer with one extra wrap bit above the RAM address.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic logic ptr_empty(input ptr_t w, input ptr_t r);
    return w == r;
  endfunction

  function automatic logic ptr_full(input ptr_t w, input ptr_t r);
    return (w[DEF_ADDR_WIDTH] != r[DEF_ADDR_WIDTH]) &&
           (w[DEF_ADDR_WIDTH-1:0] == r[DEF_ADDR_WIDTH-1:0]);
  endfunction
endpackage

// File: rtl/vfifo_skid_buf.sv
// Two-entry registered valid/ready buffer with synchronous clear.
// The producer must never push into a full buffer without a same-cycle pop.
module vfifo_skid_buf
  import vfifo_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] d0, d1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop       = (cnt != 2'd0) && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = d0;
  assign count     = cnt;

  // d0 is always the head; d1 only holds data when cnt == 2.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      case ({in_valid, pop})
        2'b01: begin
          d0  <= d1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) d0 <= in_data;
          else             d1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            d0 <= d1;
            d1 <= in_data;
          end else begin
            d0 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vfifo_ram_reader.sv
// Read-side controller for the vfifo RAM: issues port-b reads, hides the 1-cycle RAM
// latency behind a 2-entry skid buffer. Optional fill output under VFIFO_RD_FILL_EN.
module vfifo_ram_reader
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] adr_b,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] q_b,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef VFIFO_RD_FILL_EN
  ,
  output logic [ADDR_WIDTH+1:0] fill
`endif
);
  logic       inflight;
  logic       ram_empty;
  logic       pop;
  logic [1:0] buf_cnt;
  logic [2:0] occ;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign pop       = m_valid & m_ready;
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight};
  // Holding occ <= 2 guarantees the buffer has room when the issued word lands.
  assign rd_en     = !rst && !ram_empty && !flush && ((occ - {2'b00, pop}) < 3'd2);
  assign adr_b     = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
      inflight <= rd_en;
    end
  end

  // A flush clears the buffer in the same edge that drops the in-flight word.
  vfifo_skid_buf #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (inflight),
    .in_data   (q_b),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .count     (buf_cnt)
  );

`ifdef VFIFO_RD_FILL_EN
  always_ff @(posedge clk) begin
    if (rst || flush) fill <= '0;
    else              fill <= {1'b0, wr_ptr - rd_ptr} + {{(ADDR_WIDTH-1){1'b0}}, occ};
  end
`endif
endmodule

// File: tb/tb_vfifo_ram_reader.sv
// Self-checking bench for vfifo_ram_reader: vector table plus scoreboard of written words.
module tb_vfifo_ram_reader;
  import vfifo_pkg::*;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] adr_b;
  logic          rd_en;
  logic [DW-1:0] q_b;
  logic          m_valid;
  logic [DW-1:0] m_data;
`ifdef VFIFO_RD_FILL_EN
  logic [AW+1:0] fill;
`endif

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] exp_q [$];
  int n_chk = 0, n_fail = 0, n_issue = 0, n_pop = 0, cyc = 0, first_v = -1, last_v = -1;

  typedef struct {
    logic          wr;
    logic [DW-1:0] wdata;
    logic          rdy;
    logic          exp_rd_en;
    logic          exp_m_valid;
    logic [AW:0]   exp_rd_ptr;
  } vec_t;
  vec_t vecs [9];

  vfifo_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .adr_b   (adr_b),
    .rd_en   (rd_en),
    .q_b     (q_b),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef VFIFO_RD_FILL_EN
    ,
    .fill    (fill)
`endif
  );

  always #5 clk = ~clk;

  // Port-b of the RAM: registered read.
  always @(posedge clk) if (rd_en) q_b <= mem[adr_b];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Settle inputs applied at negedge, then account for this cycle's issue and pop.
  task automatic step_begin();
    #1;
    if (rd_en) n_issue++;
    if (m_valid) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (m_valid && m_ready && !flush) begin
      n_pop++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_pop: got word %0h, expected no word", m_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("FAIL m_data: got %0h, expected %0h", m_data, e);
        end
      end
    end
  endtask

  task automatic step_end();
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick();
    step_begin();
    step_end();
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0;
    tick(); tick();
    exp_q.delete();
    rst = 1'b0;
    n_issue = 0; n_pop = 0; first_v = -1; last_v = -1;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words left, expected 0", exp_q.size());
    end
    m_ready = 1'b1;
    tick(); tick();
    check("idle_m_valid", 64'(m_valid), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    @(negedge clk);
    do_reset();

    // Reset state and idle behaviour with an empty RAM.
    check("rst_rd_ptr", 64'(rd_ptr), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_begin();
      check("idle_rd_en", 64'(rd_en), 64'(0));
      check("idle_m_valid", 64'(m_valid), 64'(0));
      step_end();
    end

    // Latency and backpressure hold, cycle by cycle.
    vecs[0] = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 5'd0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd1};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd1};
    vecs[4] = '{1'b1, 32'h3C, 1'b0, 1'b1, 1'b0, 5'd1};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd2};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd2};
    vecs[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd2};
    vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd2};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) wr_word(vecs[i].wdata);
      m_ready = vecs[i].rdy;
      step_begin();
      check($sformatf("vec%0d_rd_en", i), 64'(rd_en), 64'(vecs[i].exp_rd_en));
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].exp_m_valid));
      check($sformatf("vec%0d_rd_ptr", i), 64'(rd_ptr), 64'(vecs[i].exp_rd_ptr));
      step_end();
    end
    check("vec_queue_empty", 64'(exp_q.size()), 64'(0));

    // 16 words one per cycle with m_ready=1: gapless stream.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_word(32'h1000 + 32'(i));
      tick();
    end
    drain(1'b0);
    check("stream_pops", 64'(n_pop), 64'(16));
    check("stream_span", 64'(last_v - first_v), 64'(15));
    check("stream_rd_ptr", 64'(rd_ptr), 64'(5'h10));

    // 8 pending words under backpressure: only two reads may be outstanding.
    do_reset();
    for (int i = 0; i < 8; i++) wr_word(32'h2000 + 32'(i));
    for (int i = 0; i < 6; i++) tick();
    check("bp_issues", 64'(n_issue), 64'(2));
    check("bp_rd_ptr", 64'(rd_ptr), 64'(2));
    check("bp_m_valid", 64'(m_valid), 64'(1));
    drain(1'b0);
    check("bp_total_issues", 64'(n_issue), 64'(8));
    check("bp_pops", 64'(n_pop), 64'(8));

    // 20 words across the wrap; writer must see full at wr_ptr == rd_ptr + 16.
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && !ptr_full(wr_ptr, rd_ptr); i++) begin
      wr_word($urandom);
      n++;
      tick();
    end
    check("full_rd_ptr", 64'(rd_ptr), 64'(2));
    check("full_wr_ptr", 64'(wr_ptr), 64'(18));
    check("full_flag", 64'(ptr_full(wr_ptr, rd_ptr)), 64'(1));
    for (int i = 0; i < 400 && (n < 20 || exp_q.size() != 0); i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (n < 20 && !ptr_full(wr_ptr, rd_ptr)) begin
        wr_word($urandom);
        n++;
      end
      tick();
    end
    drain(1'b1);
    check("wrap_pops", 64'(n_pop), 64'(20));
    check("wrap_rd_ptr", 64'(rd_ptr), 64'(20));

    // Flush with 2 buffered and 3 pending words.
    do_reset();
    for (int i = 0; i < 5; i++) wr_word(32'h3000 + 32'(i));
    for (int i = 0; i < 5; i++) tick();
    check("pre_flush_rd_ptr", 64'(rd_ptr), 64'(2));
    check("pre_flush_m_valid", 64'(m_valid), 64'(1));
    flush = 1'b1;
    step_begin();
    check("flush_rd_en", 64'(rd_en), 64'(0));
    step_end();
    exp_q.delete();
    flush = 1'b0;
    step_begin();
    check("post_flush_m_valid", 64'(m_valid), 64'(0));
    check("post_flush_rd_ptr", 64'(rd_ptr), 64'(5));
    check("post_flush_rd_en", 64'(rd_en), 64'(0));
`ifdef VFIFO_RD_FILL_EN
    check("post_flush_fill", 64'(fill), 64'(0));
`endif
    step_end();
    wr_word(32'h77);
    drain(1'b0);
    check("post_flush_rd_ptr2", 64'(rd_ptr), 64'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
